// File: rtl/game_step_scheduler.sv
// ============================================================================
// game_step_scheduler
// ----------------------------------------------------------------------------
// Schedules the runner game. It owns the Enable of the Timer_1ms instance and
// consumes its Tick. The 1 ms ticks are divided into game-step strobes. The
// step period shrinks by PERIOD_DEC_MS per difficulty level and never goes
// below MIN_PERIOD_MS. The level rises after every STEPS_PER_LEVEL steps and
// saturates at MAX_LEVEL.
//
// Optional feature (macro GAME_STEP_COUNTDOWN_EN): Start enters a countdown of
// COUNTDOWN_MS ticks before RUN. Without the macro, Start goes straight to RUN
// and Countdown is tied low.
//
// Ports:
//   Clk        in   system clock (50 MHz)
//   Rst        in   synchronous active-low reset
//   Start      in   level, starts/restarts a game from IDLE or OVER
//   Pause      in   level, holds the game while high in RUN
//   Collision  in   level, ends the game from RUN/PAUSED
//   Tick1ms    in   one-cycle pulse from Timer_1ms
//   TimerEn    out  Enable of Timer_1ms (registered)
//   StepPulse  out  one-cycle game-advance strobe (registered)
//   Level      out  difficulty level, 4 bits (registered)
//   Running    out  high in RUN (registered)
//   GameOver   out  high in OVER (registered)
//   Countdown  out  high in CNTDN (registered, 0 without the feature)
// ============================================================================
module game_step_scheduler #(
   parameter int START_PERIOD_MS = 500,
   parameter int PERIOD_DEC_MS   = 50,
   parameter int MIN_PERIOD_MS   = 100,
   parameter int STEPS_PER_LEVEL = 20,
   parameter int MAX_LEVEL       = 9,
   parameter int COUNTDOWN_MS    = 3000
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Start,
   input  logic       Pause,
   input  logic       Collision,
   input  logic       Tick1ms,
   output logic       TimerEn,
   output logic       StepPulse,
   output logic [3:0] Level,
   output logic       Running,
   output logic       GameOver,
   output logic       Countdown
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RUN    = 3'd1;
   localparam logic [2:0] ST_PAUSED = 3'd2;
   localparam logic [2:0] ST_OVER   = 3'd3;
`ifdef GAME_STEP_COUNTDOWN_EN
   localparam logic [2:0] ST_CNTDN  = 3'd4;
   localparam logic [2:0] ST_START  = ST_CNTDN;
   localparam logic [15:0] CD_LAST  = 16'(COUNTDOWN_MS - 1);
`else
   localparam logic [2:0] ST_START  = ST_RUN;
`endif

   localparam logic signed [16:0] START_S = 17'(START_PERIOD_MS);
   localparam logic signed [16:0] DEC_S   = 17'(PERIOD_DEC_MS);
   localparam logic signed [16:0] MIN_S   = 17'(MIN_PERIOD_MS);
   localparam logic [15:0] MIN_U          = 16'(MIN_PERIOD_MS);
   localparam logic [15:0] STEPS_LAST     = 16'(STEPS_PER_LEVEL - 1);
   localparam logic [3:0]  MAX_LVL        = 4'(MAX_LEVEL);

   // Elaboration-time parameter sanity checks.
   if (MIN_PERIOD_MS < 1) begin : g_bad_min_period
      $error("MIN_PERIOD_MS must be >= 1");
   end
   if (STEPS_PER_LEVEL < 1) begin : g_bad_steps
      $error("STEPS_PER_LEVEL must be >= 1");
   end
   if (MAX_LEVEL > 15) begin : g_bad_max_level
      $error("MAX_LEVEL must be <= 15");
   end
   if (COUNTDOWN_MS < 1) begin : g_bad_countdown
      $error("COUNTDOWN_MS must be >= 1");
   end

   logic [2:0]          state_r;
   logic [2:0]          state_nx_s;
   logic [15:0]         ms_cnt_r;
   logic [15:0]         ms_cnt_nx_s;
   logic [15:0]         step_cnt_r;
   logic [15:0]         step_cnt_nx_s;
   logic [3:0]          level_r;
   logic [3:0]          level_nx_s;
   logic                step_nx_s;
   logic signed [16:0]  period_raw_s;
   logic [15:0]         period_s;
   logic [15:0]         period_last_s;
   logic                timer_en_r;
   logic                step_pulse_r;
   logic                running_r;
   logic                game_over_r;
   logic                timer_en_nx_s;
   logic                running_nx_s;
   logic                game_over_nx_s;
`ifdef GAME_STEP_COUNTDOWN_EN
   logic [15:0]         cd_cnt_r;
   logic [15:0]         cd_cnt_nx_s;
   logic                countdown_r;
   logic                countdown_nx_s;
`endif

   // Step period for the current level, clamped to the floor (negative included).
   always_comb begin
      period_raw_s = START_S - ($signed({13'd0, level_r}) * DEC_S);
      if (period_raw_s < MIN_S) begin
         period_s = MIN_U;
      end else begin
         period_s = period_raw_s[15:0];
      end
      period_last_s = period_s - 16'd1;
   end

   // Next-state and counter logic for the game sequencer.
   always_comb begin
      state_nx_s    = state_r;
      ms_cnt_nx_s   = ms_cnt_r;
      step_cnt_nx_s = step_cnt_r;
      level_nx_s    = level_r;
      step_nx_s     = 1'b0;
`ifdef GAME_STEP_COUNTDOWN_EN
      cd_cnt_nx_s   = cd_cnt_r;
`endif
      case (state_r)
         ST_IDLE, ST_OVER: begin
            // Level survives in OVER for display until the next Start.
            if (Start) begin
               ms_cnt_nx_s   = 16'd0;
               step_cnt_nx_s = 16'd0;
               level_nx_s    = 4'd0;
`ifdef GAME_STEP_COUNTDOWN_EN
               cd_cnt_nx_s   = 16'd0;
`endif
               state_nx_s    = ST_START;
            end else begin
               state_nx_s    = state_r;
            end
         end
         ST_RUN: begin
            // Collision beats Pause beats tick counting; a blocked tick is lost.
            if (Collision) begin
               state_nx_s = ST_OVER;
            end else if (Pause) begin
               state_nx_s = ST_PAUSED;
            end else if (Tick1ms) begin
               if (ms_cnt_r == period_last_s) begin
                  ms_cnt_nx_s = 16'd0;
                  step_nx_s   = 1'b1;
                  if (step_cnt_r == STEPS_LAST) begin
                     step_cnt_nx_s = 16'd0;
                     if (level_r < MAX_LVL) begin
                        level_nx_s = level_r + 4'd1;
                     end else begin
                        level_nx_s = level_r;
                     end
                  end else begin
                     step_cnt_nx_s = step_cnt_r + 16'd1;
                  end
               end else begin
                  ms_cnt_nx_s = ms_cnt_r + 16'd1;
               end
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_PAUSED: begin
            if (Collision) begin
               state_nx_s = ST_OVER;
            end else if (!Pause) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_PAUSED;
            end
         end
`ifdef GAME_STEP_COUNTDOWN_EN
         ST_CNTDN: begin
            // Collision and Pause have no effect while counting down.
            if (Tick1ms) begin
               if (cd_cnt_r == CD_LAST) begin
                  cd_cnt_nx_s = 16'd0;
                  state_nx_s  = ST_RUN;
               end else begin
                  cd_cnt_nx_s = cd_cnt_r + 16'd1;
               end
            end else begin
               cd_cnt_nx_s = cd_cnt_r;
            end
         end
`endif
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state so the registered outputs track the state.
   always_comb begin
      running_nx_s   = (state_nx_s == ST_RUN);
      game_over_nx_s = (state_nx_s == ST_OVER);
`ifdef GAME_STEP_COUNTDOWN_EN
      countdown_nx_s = (state_nx_s == ST_CNTDN);
      timer_en_nx_s  = (state_nx_s == ST_RUN) || (state_nx_s == ST_CNTDN);
`else
      timer_en_nx_s  = (state_nx_s == ST_RUN);
`endif
   end

   // State, counters and registered outputs.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_r      <= ST_IDLE;
         ms_cnt_r     <= 16'd0;
         step_cnt_r   <= 16'd0;
         level_r      <= 4'd0;
         timer_en_r   <= 1'b0;
         step_pulse_r <= 1'b0;
         running_r    <= 1'b0;
         game_over_r  <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         ms_cnt_r     <= ms_cnt_nx_s;
         step_cnt_r   <= step_cnt_nx_s;
         level_r      <= level_nx_s;
         timer_en_r   <= timer_en_nx_s;
         step_pulse_r <= step_nx_s;
         running_r    <= running_nx_s;
         game_over_r  <= game_over_nx_s;
      end
   end

`ifdef GAME_STEP_COUNTDOWN_EN
   // Countdown counter and its indicator output.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         cd_cnt_r    <= 16'd0;
         countdown_r <= 1'b0;
      end else begin
         cd_cnt_r    <= cd_cnt_nx_s;
         countdown_r <= countdown_nx_s;
      end
   end

   assign Countdown = countdown_r;
`else
   assign Countdown = 1'b0;
`endif

   assign TimerEn   = timer_en_r;
   assign StepPulse = step_pulse_r;
   assign Level     = level_r;
   assign Running   = running_r;
   assign GameOver  = game_over_r;

endmodule
